// File: rtl/rib_fifo_slave_pkg.sv
// Shared register-window definitions for the RIB mailbox slave.
package rib_fifo_slave_pkg;

   // Register select decoded from addr_i[3:2].
   typedef enum logic [1:0] {
      REG_DATA   = 2'd0,
      REG_STATUS = 2'd1,
      REG_CTRL   = 2'd2,
      REG_RSVD   = 2'd3
   } reg_sel_e;

   // CTRL bit positions.
   localparam int CTRL_INT_EN_BIT = 0;
   localparam int CTRL_CLEAR_BIT  = 1;

   // STATUS word layout, MSB first.
   typedef struct packed {
      logic [7:0] pad;
      logic [7:0] tx_count;
      logic [7:0] rx_count;
      logic [1:0] rsvd;
      logic       rx_underflow;
      logic       tx_overflow;
      logic       tx_full;
      logic       tx_empty;
      logic       rx_full;
      logic       rx_empty;
   } status_t;

endpackage

// File: rtl/rib_fifo_slave_sync_fifo.sv
// Synchronous FIFO with a combinational head output and a flush input.
// The head reads as zero while empty so stale storage never leaks out.
module rib_fifo_slave_sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push_ok;
   logic             w_pop_ok;

   // Full/empty come from registered state only, so a same-cycle pop
   // never makes room for a push.
   assign full      = (r_count == CW'(DEPTH));
   assign empty     = (r_count == '0);
   assign count     = r_count;
   assign w_push_ok = push && !full;
   assign w_pop_ok  = pop && !empty;
   assign rdata     = empty ? '0 : r_mem[r_rd_ptr];

   // Pointer and occupancy update; reset and flush discard everything.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage write; no reset needed since the pointers define validity.
   always_ff @(posedge clk) begin
      if (w_push_ok && !rst && !clr) r_mem[r_wr_ptr] <= wdata;
   end

endmodule

// File: rtl/rib_fifo_slave.sv
// RIB mailbox slave: register window onto an RX FIFO (external producer,
// core pops) and a TX FIFO (core pushes, external consumer drains).
module rib_fifo_slave
   import rib_fifo_slave_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   input  logic        in_valid_i,
   input  logic [31:0] in_data_i,
   output logic        in_ready_o,
   output logic        out_valid_o,
   output logic [31:0] out_data_o,
   input  logic        out_ready_i,
   output logic        int_o
);
   localparam int CW = $clog2(DEPTH) + 1;

   reg_sel_e       w_sel;
   logic           w_rd;
   logic           w_wr;
   logic           w_data_rd;
   logic           w_data_wr;
   logic           w_ctrl_wr;
   logic           w_clear;
   logic           w_rx_push;
   logic           w_rx_pop;
   logic           w_tx_pop;
   logic [31:0]    w_rx_rdata;
   logic [31:0]    w_tx_rdata;
   logic           w_rx_full;
   logic           w_rx_empty;
   logic           w_tx_full;
   logic           w_tx_empty;
   logic [CW-1:0]  w_rx_count;
   logic [CW-1:0]  w_tx_count;
   status_t        w_status;
   logic           r_rx_int_en;
   logic           r_tx_overflow;
   logic           r_rx_underflow;
   logic           w_unused_bits;

   assign w_sel     = reg_sel_e'(addr_i[3:2]);
   assign w_rd      = req_i && !we_i;
   assign w_wr      = req_i && we_i;
   assign w_data_rd = w_rd && (w_sel == REG_DATA);
   assign w_data_wr = w_wr && (w_sel == REG_DATA);
   assign w_ctrl_wr = w_wr && (w_sel == REG_CTRL);
   assign w_clear   = w_ctrl_wr && data_i[CTRL_CLEAR_BIT];
   assign w_rx_push = in_valid_i && !w_rx_full;
   assign w_rx_pop  = w_data_rd && !w_rx_empty;
   assign w_tx_pop  = out_ready_i && !w_tx_empty;

   // Only addr_i[3:2] is decoded; the remaining address bits are don't-care.
   assign w_unused_bits = ^{addr_i[31:4], addr_i[1:0]};

   rib_fifo_slave_sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_rx_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (w_clear),
      .push  (w_rx_push),
      .pop   (w_rx_pop),
      .wdata (in_data_i),
      .rdata (w_rx_rdata),
      .full  (w_rx_full),
      .empty (w_rx_empty),
      .count (w_rx_count)
   );

   rib_fifo_slave_sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (w_clear),
      .push  (w_data_wr),
      .pop   (w_tx_pop),
      .wdata (data_i),
      .rdata (w_tx_rdata),
      .full  (w_tx_full),
      .empty (w_tx_empty),
      .count (w_tx_count)
   );

   // CTRL enable and sticky error flags; a clear beats a same-cycle set.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_int_en    <= 1'b0;
         r_tx_overflow  <= 1'b0;
         r_rx_underflow <= 1'b0;
      end else begin
         if (w_ctrl_wr) r_rx_int_en <= data_i[CTRL_INT_EN_BIT];
         if (w_clear) begin
            r_tx_overflow  <= 1'b0;
            r_rx_underflow <= 1'b0;
         end else begin
            if (w_data_wr && w_tx_full)  r_tx_overflow  <= 1'b1;
            if (w_data_rd && w_rx_empty) r_rx_underflow <= 1'b1;
         end
      end
   end

   // Assemble the STATUS word from live FIFO state and sticky flags.
   always_comb begin
      w_status              = '0;
      w_status.rx_empty     = w_rx_empty;
      w_status.rx_full      = w_rx_full;
      w_status.tx_empty     = w_tx_empty;
      w_status.tx_full      = w_tx_full;
      w_status.tx_overflow  = r_tx_overflow;
      w_status.rx_underflow = r_rx_underflow;
      w_status.rx_count     = 8'(w_rx_count);
      w_status.tx_count     = 8'(w_tx_count);
   end

   // Zero-latency read mux; quiet whenever no read access is in progress.
   always_comb begin
      data_o = '0;
      if (w_rd) begin
         case (w_sel)
            REG_DATA:   data_o = w_rx_rdata;
            REG_STATUS: data_o = w_status;
            REG_CTRL:   data_o = {31'd0, r_rx_int_en};
            default:    data_o = '0;
         endcase
      end
   end

   assign in_ready_o  = !w_rx_full;
   assign out_valid_o = !w_tx_empty;
   assign out_data_o  = w_tx_rdata;
   assign int_o       = r_rx_int_en && !w_rx_empty;

endmodule

// File: tb/tb_rib_fifo_slave.sv
// Directed self-checking bench for the RIB mailbox slave (DEPTH = 8).
module tb_rib_fifo_slave;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_i = 1'b0;
   logic        we_i = 1'b0;
   logic [31:0] addr_i = '0;
   logic [31:0] data_i = '0;
   logic [31:0] data_o;
   logic        in_valid_i = 1'b0;
   logic [31:0] in_data_i = '0;
   logic        in_ready_o;
   logic        out_valid_o;
   logic [31:0] out_data_o;
   logic        out_ready_i = 1'b0;
   logic        int_o;

   int checks = 0;
   int failures = 0;

   localparam logic [31:0] A_DATA   = 32'h0;
   localparam logic [31:0] A_STATUS = 32'h4;
   localparam logic [31:0] A_CTRL   = 32'h8;

   rib_fifo_slave #(.DEPTH(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_i       (req_i),
      .we_i        (we_i),
      .addr_i      (addr_i),
      .data_i      (data_i),
      .data_o      (data_o),
      .in_valid_i  (in_valid_i),
      .in_data_i   (in_data_i),
      .in_ready_o  (in_ready_o),
      .out_valid_o (out_valid_o),
      .out_data_o  (out_data_o),
      .out_ready_i (out_ready_i),
      .int_o       (int_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
         $error("check %s did not match", tag);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      req_i = 1'b1; we_i = 1'b0; addr_i = a;
      #1;
      d = data_o;
      $display("RD  addr=0x%0h data=0x%08h", a, d);
      cycle();
      req_i = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      req_i = 1'b1; we_i = 1'b1; addr_i = a; data_i = d;
      $display("WR  addr=0x%0h data=0x%08h", a, d);
      cycle();
      req_i = 1'b0; we_i = 1'b0;
   endtask

   task automatic push(input logic [31:0] d);
      in_valid_i = 1'b1; in_data_i = d;
      $display("PUSH data=0x%08h", d);
      cycle();
      in_valid_i = 1'b0;
   endtask

   initial begin
      logic [31:0] v;

      // Reset and idle state.
      cycle(); cycle();
      rst = 1'b0;
      #1;
      chk("reset_in_ready", {31'd0, in_ready_o}, 32'd1);
      chk("reset_out_valid", {31'd0, out_valid_o}, 32'd0);
      chk("reset_out_data", out_data_o, 32'd0);
      chk("reset_int", {31'd0, int_o}, 32'd0);
      chk("idle_data_o", data_o, 32'd0);
      rd(A_STATUS, v); chk("reset_status", v, 32'h0000_0005);

      // RX path with interrupt enabled.
      wr(A_CTRL, 32'h1);
      rd(A_CTRL, v); chk("ctrl_int_en", v, 32'h1);
      in_valid_i = 1'b1; in_data_i = 32'h11;
      #1;
      chk("int_before_push_edge", {31'd0, int_o}, 32'd0);
      cycle();
      in_valid_i = 1'b0;
      chk("int_after_first_push", {31'd0, int_o}, 32'd1);
      push(32'h22);
      push(32'h33);
      chk("idle_data_o_nonempty", data_o, 32'd0);
      rd(A_STATUS, v); chk("rx3_status", v, 32'h0000_0304);
      rd(A_DATA, v); chk("rx_pop0", v, 32'h11);
      rd(A_DATA, v); chk("rx_pop1", v, 32'h22);
      chk("int_still_high", {31'd0, int_o}, 32'd1);
      rd(A_DATA, v); chk("rx_pop2", v, 32'h33);
      chk("int_after_last_pop", {31'd0, int_o}, 32'd0);
      rd(A_DATA, v); chk("rx_underflow_data", v, 32'd0);
      rd(A_STATUS, v); chk("rx_underflow_status", v, 32'h0000_0025);

      // Clear concurrent with a producer push: push lost, sticky cleared.
      in_valid_i = 1'b1; in_data_i = 32'h44;
      wr(A_CTRL, 32'h3);
      in_valid_i = 1'b0;
      rd(A_STATUS, v); chk("clear_status", v, 32'h0000_0005);
      rd(A_CTRL, v); chk("clear_ctrl", v, 32'h1);
      chk("clear_int", {31'd0, int_o}, 32'd0);

      // TX overflow with consumer stalled, then drain in order.
      for (int i = 0; i < 9; i++) wr(A_DATA, 32'hA0 + i);
      rd(A_STATUS, v); chk("tx_full_status", v, 32'h0008_0019);
      chk("tx_out_valid", {31'd0, out_valid_o}, 32'd1);
      out_ready_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("tx_drain_valid", {31'd0, out_valid_o}, 32'd1);
         chk("tx_drain_data", out_data_o, 32'hA0 + i);
         $display("POP  data=0x%08h", out_data_o);
         cycle();
      end
      out_ready_i = 1'b0;
      chk("tx_drained_valid", {31'd0, out_valid_o}, 32'd0);
      rd(A_STATUS, v); chk("tx_drained_status", v, 32'h0000_0015);
      wr(A_CTRL, 32'h2);
      rd(A_STATUS, v); chk("clear2_status", v, 32'h0000_0005);
      rd(A_CTRL, v); chk("clear2_ctrl", v, 32'h0);

      // Full RX: simultaneous pop and producer push; push must be refused.
      for (int i = 0; i < 8; i++) push(32'hB0 + i);
      chk("rx_full_in_ready", {31'd0, in_ready_o}, 32'd0);
      rd(A_STATUS, v); chk("rx_full_status", v, 32'h0000_0806);
      req_i = 1'b1; we_i = 1'b0; addr_i = A_DATA;
      in_valid_i = 1'b1; in_data_i = 32'hCC;
      #1;
      chk("popfull_data", data_o, 32'hB0);
      chk("popfull_in_ready", {31'd0, in_ready_o}, 32'd0);
      $display("RD  addr=0x0 data=0x%08h (with producer push)", data_o);
      cycle();
      req_i = 1'b0; in_valid_i = 1'b0;
      rd(A_STATUS, v); chk("popfull_status", v, 32'h0000_0704);
      for (int i = 1; i < 8; i++) begin
         rd(A_DATA, v); chk("popfull_drain", v, 32'hB0 + i);
      end
      rd(A_STATUS, v); chk("popfull_empty_status", v, 32'h0000_0005);

      // Reset with four words in each FIFO and accesses in flight.
      wr(A_CTRL, 32'h1);
      for (int i = 0; i < 4; i++) begin
         push(32'hD0 + i);
         wr(A_DATA, 32'hE0 + i);
      end
      rd(A_STATUS, v); chk("prereset_status", v, 32'h0004_0400);
      chk("prereset_int", {31'd0, int_o}, 32'd1);
      rst = 1'b1;
      in_valid_i = 1'b1; in_data_i = 32'hDD;
      req_i = 1'b1; we_i = 1'b1; addr_i = A_DATA; data_i = 32'hEE;
      cycle();
      rst = 1'b0; in_valid_i = 1'b0; req_i = 1'b0; we_i = 1'b0;
      #1;
      chk("rst2_in_ready", {31'd0, in_ready_o}, 32'd1);
      chk("rst2_out_valid", {31'd0, out_valid_o}, 32'd0);
      chk("rst2_out_data", out_data_o, 32'd0);
      chk("rst2_int", {31'd0, int_o}, 32'd0);
      rd(A_STATUS, v); chk("rst2_status", v, 32'h0000_0005);
      rd(A_CTRL, v); chk("rst2_ctrl", v, 32'h0);
      rd(A_DATA, v); chk("rst2_data", v, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
